// File: rtl/inst_encoder_loader_pkg.sv
// Shared RV32IM encoding definitions: op enumeration, base opcodes, funct7 values
// and a per-op lookup of format/opcode/funct3/funct7 used by encoder and decoder.
package inst_encoder_loader_pkg;

  typedef enum logic [5:0] {
    ENC_LUI, ENC_AUIPC, ENC_JAL, ENC_JALR,
    ENC_BEQ, ENC_BNE, ENC_BLT, ENC_BGE, ENC_BLTU, ENC_BGEU,
    ENC_LB, ENC_LH, ENC_LW, ENC_LBU, ENC_LHU,
    ENC_SB, ENC_SH, ENC_SW,
    ENC_ADDI, ENC_SLTI, ENC_SLTIU, ENC_XORI, ENC_ORI, ENC_ANDI,
    ENC_SLLI, ENC_SRLI, ENC_SRAI,
    ENC_ADD, ENC_SUB, ENC_SLL, ENC_SLT, ENC_SLTU, ENC_XOR, ENC_SRL, ENC_SRA, ENC_OR, ENC_AND,
    ENC_MUL, ENC_MULH, ENC_MULHSU, ENC_MULHU, ENC_DIV, ENC_DIVU, ENC_REM, ENC_REMU
  } enc_op_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MUL  = 7'b0000001;

  // FMT_SH is the I-format variant whose upper bits carry funct7 and a 5-bit shamt
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J} enc_fmt_t;

  typedef struct packed {
    logic       ok;
    enc_fmt_t   fmt;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
  } op_info_t;

  function automatic op_info_t mk(input enc_fmt_t fmt, input logic [6:0] opc,
                                  input logic [2:0] f3, input logic [6:0] f7);
    op_info_t i;
    i.ok     = 1'b1;
    i.fmt    = fmt;
    i.opcode = opc;
    i.f3     = f3;
    i.f7     = f7;
    return i;
  endfunction

  function automatic op_info_t op_info(input logic [5:0] op);
    op_info_t i;
    i = mk(FMT_R, OP_REG, 3'd0, FUNCT7_BASE);
    case (op)
      ENC_LUI:    i = mk(FMT_U,  OP_LUI,    3'd0, FUNCT7_BASE);
      ENC_AUIPC:  i = mk(FMT_U,  OP_AUIPC,  3'd0, FUNCT7_BASE);
      ENC_JAL:    i = mk(FMT_J,  OP_JAL,    3'd0, FUNCT7_BASE);
      ENC_JALR:   i = mk(FMT_I,  OP_JALR,   3'd0, FUNCT7_BASE);
      ENC_BEQ:    i = mk(FMT_B,  OP_BRANCH, 3'd0, FUNCT7_BASE);
      ENC_BNE:    i = mk(FMT_B,  OP_BRANCH, 3'd1, FUNCT7_BASE);
      ENC_BLT:    i = mk(FMT_B,  OP_BRANCH, 3'd4, FUNCT7_BASE);
      ENC_BGE:    i = mk(FMT_B,  OP_BRANCH, 3'd5, FUNCT7_BASE);
      ENC_BLTU:   i = mk(FMT_B,  OP_BRANCH, 3'd6, FUNCT7_BASE);
      ENC_BGEU:   i = mk(FMT_B,  OP_BRANCH, 3'd7, FUNCT7_BASE);
      ENC_LB:     i = mk(FMT_I,  OP_LOAD,   3'd0, FUNCT7_BASE);
      ENC_LH:     i = mk(FMT_I,  OP_LOAD,   3'd1, FUNCT7_BASE);
      ENC_LW:     i = mk(FMT_I,  OP_LOAD,   3'd2, FUNCT7_BASE);
      ENC_LBU:    i = mk(FMT_I,  OP_LOAD,   3'd4, FUNCT7_BASE);
      ENC_LHU:    i = mk(FMT_I,  OP_LOAD,   3'd5, FUNCT7_BASE);
      ENC_SB:     i = mk(FMT_S,  OP_STORE,  3'd0, FUNCT7_BASE);
      ENC_SH:     i = mk(FMT_S,  OP_STORE,  3'd1, FUNCT7_BASE);
      ENC_SW:     i = mk(FMT_S,  OP_STORE,  3'd2, FUNCT7_BASE);
      ENC_ADDI:   i = mk(FMT_I,  OP_IMM,    3'd0, FUNCT7_BASE);
      ENC_SLTI:   i = mk(FMT_I,  OP_IMM,    3'd2, FUNCT7_BASE);
      ENC_SLTIU:  i = mk(FMT_I,  OP_IMM,    3'd3, FUNCT7_BASE);
      ENC_XORI:   i = mk(FMT_I,  OP_IMM,    3'd4, FUNCT7_BASE);
      ENC_ORI:    i = mk(FMT_I,  OP_IMM,    3'd6, FUNCT7_BASE);
      ENC_ANDI:   i = mk(FMT_I,  OP_IMM,    3'd7, FUNCT7_BASE);
      ENC_SLLI:   i = mk(FMT_SH, OP_IMM,    3'd1, FUNCT7_BASE);
      ENC_SRLI:   i = mk(FMT_SH, OP_IMM,    3'd5, FUNCT7_BASE);
      ENC_SRAI:   i = mk(FMT_SH, OP_IMM,    3'd5, FUNCT7_ALT);
      ENC_ADD:    i = mk(FMT_R,  OP_REG,    3'd0, FUNCT7_BASE);
      ENC_SUB:    i = mk(FMT_R,  OP_REG,    3'd0, FUNCT7_ALT);
      ENC_SLL:    i = mk(FMT_R,  OP_REG,    3'd1, FUNCT7_BASE);
      ENC_SLT:    i = mk(FMT_R,  OP_REG,    3'd2, FUNCT7_BASE);
      ENC_SLTU:   i = mk(FMT_R,  OP_REG,    3'd3, FUNCT7_BASE);
      ENC_XOR:    i = mk(FMT_R,  OP_REG,    3'd4, FUNCT7_BASE);
      ENC_SRL:    i = mk(FMT_R,  OP_REG,    3'd5, FUNCT7_BASE);
      ENC_SRA:    i = mk(FMT_R,  OP_REG,    3'd5, FUNCT7_ALT);
      ENC_OR:     i = mk(FMT_R,  OP_REG,    3'd6, FUNCT7_BASE);
      ENC_AND:    i = mk(FMT_R,  OP_REG,    3'd7, FUNCT7_BASE);
      ENC_MUL:    i = mk(FMT_R,  OP_REG,    3'd0, FUNCT7_MUL);
      ENC_MULH:   i = mk(FMT_R,  OP_REG,    3'd1, FUNCT7_MUL);
      ENC_MULHSU: i = mk(FMT_R,  OP_REG,    3'd2, FUNCT7_MUL);
      ENC_MULHU:  i = mk(FMT_R,  OP_REG,    3'd3, FUNCT7_MUL);
      ENC_DIV:    i = mk(FMT_R,  OP_REG,    3'd4, FUNCT7_MUL);
      ENC_DIVU:   i = mk(FMT_R,  OP_REG,    3'd5, FUNCT7_MUL);
      ENC_REM:    i = mk(FMT_R,  OP_REG,    3'd6, FUNCT7_MUL);
      ENC_REMU:   i = mk(FMT_R,  OP_REG,    3'd7, FUNCT7_MUL);
      default:    i.ok = 1'b0;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/inst_encoder_loader_rv32_encode_word.sv
// Combinational packer: field-level request -> 32-bit RV32IM word plus an
// illegal flag for undefined ops or immediates that do not fit the format.
module rv32_encode_word
  import inst_encoder_loader_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  op_info_t info;
  logic     fits12, fits13, fits21;

  always_comb begin
    info   = op_info(op_i);
    fits12 = (imm_i[31:11] == {21{imm_i[11]}});
    fits13 = (imm_i[31:12] == {20{imm_i[12]}});
    fits21 = (imm_i[31:20] == {12{imm_i[20]}});
    word_o    = '0;
    illegal_o = ~info.ok;
    case (info.fmt)
      FMT_R: word_o = {info.f7, rs2_i, rs1_i, info.f3, rd_i, info.opcode};
      FMT_I: begin
        word_o    = {imm_i[11:0], rs1_i, info.f3, rd_i, info.opcode};
        illegal_o = illegal_o | ~fits12;
      end
      FMT_SH: begin
        word_o    = {info.f7, imm_i[4:0], rs1_i, info.f3, rd_i, info.opcode};
        illegal_o = illegal_o | (imm_i[31:5] != '0);
      end
      FMT_S: begin
        word_o    = {imm_i[11:5], rs2_i, rs1_i, info.f3, imm_i[4:0], info.opcode};
        illegal_o = illegal_o | ~fits12;
      end
      FMT_B: begin
        word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, info.f3,
                     imm_i[4:1], imm_i[11], info.opcode};
        illegal_o = illegal_o | ~fits13 | imm_i[0];
      end
      FMT_U: begin
        word_o    = {imm_i[31:12], rd_i, info.opcode};
        illegal_o = illegal_o | (imm_i[11:0] != '0);
      end
      FMT_J: begin
        word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, info.opcode};
        illegal_o = illegal_o | ~fits21 | imm_i[0];
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// Instruction loader: accepts field requests, encodes them and writes the words
// sequentially into IMEM through a one-entry output register with pass-through.
module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 1024
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [5:0]        req_op_i,
  input  logic [4:0]        req_rd_i,
  input  logic [4:0]        req_rs1_i,
  input  logic [4:0]        req_rs2_i,
  input  logic [31:0]       req_imm_i,
  output logic              mem_we_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [15:0]       count_o,
  output logic              full_o,
  output logic              err_o,
  output logic [15:0]       err_index_o
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       idx_q, idx_d, idx_adv;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic [15:0]       err_idx_q, err_idx_d;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              ack, accept, last_slot;

  rv32_encode_word u_enc (
    .op_i      (req_op_i),
    .rd_i      (req_rd_i),
    .rs1_i     (req_rs1_i),
    .rs2_i     (req_rs2_i),
    .imm_i     (req_imm_i),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  // A pending write to the final slot blocks the pass-through so nothing lands past DEPTH
  assign last_slot   = we_q & (({1'b0, idx_q} + 17'd1) == DEPTH_L);
  assign ack         = we_q & mem_ready_i;
  assign req_ready_o = rstn_i & ~start_i & ~full_q & ~last_slot & (~we_q | mem_ready_i);
  assign accept      = req_valid_i & req_ready_o;
  assign idx_adv     = idx_q + {15'd0, ack};

  always_comb begin
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    full_d    = full_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    if (ack) begin
      we_d   = 1'b0;
      idx_d  = idx_adv;
      full_d = ({1'b0, idx_adv} == DEPTH_L);
    end
    if (accept) begin
      if (!enc_illegal) begin
        we_d    = 1'b1;
        wdata_d = enc_word;
        addr_d  = BASE_ADDR + (ADDR_W'(idx_adv) << 2);
      end else begin
        err_d = 1'b1;
        if (!err_q) err_idx_d = idx_adv;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || start_i) begin
      we_q      <= 1'b0;
      addr_q    <= BASE_ADDR;
      wdata_q   <= '0;
      idx_q     <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      idx_q     <= idx_d;
      full_q    <= full_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign count_o     = idx_q;
  assign full_o      = full_q;
  assign err_o       = err_q;
  assign err_index_o = err_idx_q;

endmodule
